// File: rtl/nibble_seq_pkg.sv
// nibble_sequencer shared definitions:
// command codes, instruction fields, FSM states.
package nibble_seq_pkg;

  localparam logic [1:0] FN_NOP   = 2'b00;
  localparam logic [1:0] FN_WRITE = 2'b01;
  localparam logic [1:0] FN_RUN   = 2'b10;
  localparam logic [1:0] FN_CLEAR = 2'b11;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [1:0] SUB_HALT = 2'b00;
  localparam logic [1:0] SUB_OUT  = 2'b01;
  localparam logic [1:0] SUB_SHL  = 2'b10;
  localparam logic [1:0] SUB_JMP0 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

endpackage

// File: rtl/nibble_seq_alu.sv
// nibble_sequencer accumulator ALU:
// next acc for LDI/ADD/SUB and SHL (opcode 11).
module nibble_seq_alu
  import nibble_seq_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] k,
  input  logic [3:0] acc,
  output logic [3:0] y
);

  always_comb begin
    y = acc;
    unique case (op)
      OP_LDI: y = {2'b00, k};
      OP_ADD: y = acc + {2'b00, k};
      OP_SUB: y = acc - {2'b00, k};
      OP_SYS: y = {acc[2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/nibble_sequencer.sv
// nibble_sequencer: 4-bit micro-sequencer with
// loadable program memory and accumulator.
module nibble_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PW = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic [1:0]    fn;
  logic [1:0]    fn_q;
  logic [3:0]    data;
  state_t        state;
  state_t        state_n;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_n;
  logic [PW:0]   pc_inc;
  logic [PW:0]   wptr;
  logic [PW:0]   wptr_n;
  logic [3:0]    acc;
  logic [3:0]    acc_n;
  logic [3:0]    out_reg;
  logic [3:0]    out_n;
  logic [3:0]    alu_y;
  logic [3:0]    instr;
  logic [1:0]    k;
  logic          strobe;
  logic          strobe_n;
  logic          we;
  logic          fire;
  logic          full;
  logic          advance;
  logic [3:0]    mem [DEPTH];

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign fn    = io_in[3:2];
  assign data  = io_in[7:4];

  // edge-detect on fn so a held command fires once
  assign fire   = (fn != FN_NOP) && (fn_q == FN_NOP);
  assign instr  = mem[pc];
  assign k      = instr[1:0];
  assign pc_inc = {1'b0, pc} + (PW+1)'(1);
  assign full   = (wptr == (PW+1)'(DEPTH));

  nibble_seq_alu u_alu (
    .op  (instr[3:2]),
    .k   (k),
    .acc (acc),
    .y   (alu_y)
  );

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    wptr_n   = wptr;
    acc_n    = acc;
    out_n    = out_reg;
    strobe_n = 1'b0;
    we       = 1'b0;
    advance  = 1'b0;

    if (state == S_RUN) begin
      if (instr[3:2] != OP_SYS) begin
        acc_n   = alu_y;
        advance = 1'b1;
      end else begin
        unique case (k)
          SUB_HALT: state_n = S_HALT;
          SUB_OUT: begin
            out_n    = acc;
            strobe_n = 1'b1;
            advance  = 1'b1;
          end
          SUB_SHL: begin
            acc_n   = alu_y;
            advance = 1'b1;
          end
          SUB_JMP0: pc_n = '0;
        endcase
      end
      if (advance) begin
        pc_n = pc_inc[PW-1:0];
        if (pc_inc == wptr) state_n = S_HALT;
      end
    end

    // commands override execution; out/strobe survive CLEAR
    if (fire) begin
      unique case (fn)
        FN_WRITE: begin
          if (state != S_RUN && !full) begin
            we     = 1'b1;
            wptr_n = wptr + (PW+1)'(1);
          end
        end
        FN_RUN: begin
          if (state != S_RUN) begin
            pc_n    = '0;
            acc_n   = '0;
            state_n = (wptr == '0) ? S_HALT : S_RUN;
          end
        end
        FN_CLEAR: begin
          wptr_n  = '0;
          pc_n    = '0;
          acc_n   = '0;
          state_n = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      fn_q    <= FN_NOP;
      pc      <= '0;
      wptr    <= '0;
      acc     <= '0;
      out_reg <= '0;
      strobe  <= 1'b0;
    end else begin
      state   <= state_n;
      fn_q    <= fn;
      pc      <= pc_n;
      wptr    <= wptr_n;
      acc     <= acc_n;
      out_reg <= out_n;
      strobe  <= strobe_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr[PW-1:0]] <= data;
  end

  assign io_out = {out_reg, state == S_RUN, full,
                   state == S_HALT, strobe};

endmodule
